// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional feature macro used by this slice: DMEM_PARITY_EN.
package dmem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0001_0000;

    // Buffered word indices are carried at full width (a 32-bit byte address
    // has at most 30 word-index bits); each instance uses its low ADDR_W bits.
    localparam int SB_IDX_W = 30;

    typedef struct packed {
        logic [SB_IDX_W-1:0] idx;
        logic [31:0]         data;
        logic [3:0]          strb;
    } sb_entry_t;

    // Which single array access the responder performs this cycle.
    typedef enum logic [1:0] {
        PORT_IDLE,
        PORT_READ,
        PORT_DRAIN
    } port_op_e;

    // Overlay the strobed bytes of new_data onto old_data.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_data,
                                               input logic [31:0] new_data,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_data;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // True when addr falls inside the 4*2**addr_w byte window starting at base.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base = DEFAULT_BASE_ADDR,
                                      input int          addr_w = 12);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (33'd4 << addr_w);
        return (a >= lo) && (a < hi);
    endfunction

    // One even-parity bit per byte: the bit makes the byte's ones-count even.
    function automatic logic [3:0] byte_parity(input logic [31:0] w);
        logic [3:0] p;
        for (int b = 0; b < 4; b++) begin
            p[b] = ^w[8*b +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/dmem_store_buffer.sv
// Small circular store buffer: FIFO of pending byte-strobed stores with a
// combinational per-byte lookup returning the youngest buffered byte for a word.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int SB_DEPTH = 2
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  sb_entry_t           push_entry,
    input  logic                drain,
    output sb_entry_t           head_entry,
    output logic                full,
    output logic                empty,
    input  logic [SB_IDX_W-1:0] lookup_idx,
    output logic [31:0]         fwd_data,
    output logic [3:0]          fwd_mask
);

    localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    sb_entry_t          entries [SB_DEPTH];
    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;

    // Entry storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_q] <= push_entry;
        end
    end

    // Head/tail wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + 1'b1;
            end
            if (drain) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_entry = entries[head_q];
    assign full       = (count_q == CNT_W'(SB_DEPTH));
    assign empty      = (count_q == '0);

    // Walk oldest to youngest so a younger matching byte overwrites an older one.
    always_comb begin
        logic [PTR_W-1:0] pos;
        fwd_data = '0;
        fwd_mask = '0;
        pos      = head_q;
        for (int i = 0; i < SB_DEPTH; i++) begin
            pos = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (entries[pos].idx == lookup_idx)) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[pos].strb[b]) begin
                        fwd_data[8*b +: 8] = entries[pos].data[8*b +: 8];
                        fwd_mask[b]        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: registered word loads, buffered byte-strobed stores
// drained into a single-port word array, and store-to-load byte forwarding.
// Optional macro DMEM_PARITY_EN adds per-byte parity storage and mem_rd_perr.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          SB_DEPTH  = 2
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_re,
    input  logic [31:0] mem_rd_addr,
    output logic [31:0] mem_rd_data,
    output logic        mem_rd_valid,
    output logic        mem_rd_err,
    input  logic        mem_we,
    input  logic [31:0] mem_wr_addr,
    input  logic [31:0] mem_wr_data,
    input  logic [3:0]  mem_wr_strb,
    output logic        mem_wr_ready,
    output logic        mem_wr_err
`ifdef DMEM_PARITY_EN
    ,
    output logic        mem_rd_perr
`endif
);

    localparam int WORDS = 2**ADDR_W;

    logic [31:0]       rd_off;
    logic [31:0]       wr_off;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              rd_in_range;
    logic              wr_in_range;

    port_op_e          port_op;
    logic              serve;
    logic              drain;
    logic              wr_accept;
    logic              push;
    sb_entry_t         push_entry;

    sb_entry_t         sb_head;
    logic              sb_full;
    logic              sb_empty;
    logic [31:0]       fwd_data;
    logic [3:0]        fwd_mask;
    logic [ADDR_W-1:0] head_idx;

    logic [31:0]       mem_array [WORDS];
    logic [31:0]       array_word;
    logic [31:0]       drain_word;
    logic [31:0]       load_word;
    logic [3:0]        from_array;

    assign rd_off      = mem_rd_addr - BASE_ADDR;
    assign wr_off      = mem_wr_addr - BASE_ADDR;
    assign rd_idx      = rd_off[ADDR_W+1:2];
    assign wr_idx      = wr_off[ADDR_W+1:2];
    assign rd_in_range = in_range(mem_rd_addr, BASE_ADDR, ADDR_W);
    assign wr_in_range = in_range(mem_wr_addr, BASE_ADDR, ADDR_W);

    // One array access per cycle: a full buffer must drain, otherwise loads win.
    always_comb begin
        port_op = PORT_IDLE;
        if (!rst_n) begin
            port_op = PORT_IDLE;
        end else if (sb_full) begin
            port_op = PORT_DRAIN;
        end else if (mem_re) begin
            port_op = PORT_READ;
        end else if (!sb_empty) begin
            port_op = PORT_DRAIN;
        end
    end

    assign serve        = (port_op == PORT_READ);
    assign drain        = (port_op == PORT_DRAIN);
    assign mem_wr_ready = !sb_full || drain;
    assign wr_accept    = mem_we && mem_wr_ready;
    assign push         = wr_accept && wr_in_range;

    // Out-of-range stores are accepted but never enter the buffer.
    always_comb begin
        push_entry      = '0;
        push_entry.idx  = SB_IDX_W'(wr_idx);
        push_entry.data = mem_wr_data;
        push_entry.strb = mem_wr_strb;
    end

    dmem_store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .drain      (drain),
        .head_entry (sb_head),
        .full       (sb_full),
        .empty      (sb_empty),
        .lookup_idx (SB_IDX_W'(rd_idx)),
        .fwd_data   (fwd_data),
        .fwd_mask   (fwd_mask)
    );

    assign head_idx   = sb_head.idx[ADDR_W-1:0];
    assign array_word = mem_array[rd_idx];
    assign drain_word = byte_merge(mem_array[head_idx], sb_head.data, sb_head.strb);

    // Array contents are deliberately not reset; only drains write them.
    always_ff @(posedge clk) begin
        if (drain) begin
            mem_array[head_idx] <= drain_word;
        end
    end

    // Per byte: same-cycle store beats the buffer, the buffer beats the array.
    always_comb begin
        load_word  = array_word;
        from_array = 4'hF;
        for (int b = 0; b < 4; b++) begin
            if (push && (wr_idx == rd_idx) && mem_wr_strb[b]) begin
                load_word[8*b +: 8] = mem_wr_data[8*b +: 8];
                from_array[b]       = 1'b0;
            end else if (fwd_mask[b]) begin
                load_word[8*b +: 8] = fwd_data[8*b +: 8];
                from_array[b]       = 1'b0;
            end
        end
    end

    // Response registers; read data holds whenever no load is served.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rd_data  <= '0;
            mem_rd_valid <= 1'b0;
            mem_rd_err   <= 1'b0;
            mem_wr_err   <= 1'b0;
        end else begin
            mem_rd_valid <= serve;
            mem_rd_err   <= serve && !rd_in_range;
            mem_wr_err   <= wr_accept && !wr_in_range;
            if (serve) begin
                mem_rd_data <= rd_in_range ? load_word : 32'h0;
            end
        end
    end

`ifdef DMEM_PARITY_EN
    logic [3:0] par_array [WORDS];
    logic       perr_now;

    // Parity is generated from the merged word actually written at drain.
    always_ff @(posedge clk) begin
        if (drain) begin
            par_array[head_idx] <= byte_parity(drain_word);
        end
    end

    assign perr_now = serve && rd_in_range &&
                      (|(from_array & (byte_parity(array_word) ^ par_array[rd_idx])));

    // Parity flag aligns with the load response it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rd_perr <= 1'b0;
        end else begin
            mem_rd_perr <= perr_now;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rd_off[31:ADDR_W+2], rd_off[1:0],
                           wr_off[31:ADDR_W+2], wr_off[1:0],
                           sb_head.idx[SB_IDX_W-1:ADDR_W]};
`else
    logic unused_bits;
    assign unused_bits = ^{rd_off[31:ADDR_W+2], rd_off[1:0],
                           wr_off[31:ADDR_W+2], wr_off[1:0],
                           sb_head.idx[SB_IDX_W-1:ADDR_W], from_array};
`endif

endmodule
